// File: rtl/fma_arb_pkg.sv
// Shared types and constants for the FMA issue arbiter and its tag pipeline.
package fma_arb_pkg;

  localparam int unsigned FMA_NREQ = 2;

  localparam logic FMA_REQ_FPU = 1'b0;
  localparam logic FMA_REQ_DIV = 1'b1;

  typedef struct packed {
    logic valid;
    logic owner;
  } tag_t;

endpackage

// File: rtl/fma_arb_if.sv
// Requester/FMA handshake bundle between the two requesters and fma_arb.
interface fma_arb_if;

  logic [fma_arb_pkg::FMA_NREQ-1:0] req_valid;
  logic [fma_arb_pkg::FMA_NREQ-1:0] req_ready;
  logic [fma_arb_pkg::FMA_NREQ-1:0] flush;
  logic [fma_arb_pkg::FMA_NREQ-1:0] rsp_valid;
  logic [fma_arb_pkg::FMA_NREQ-1:0] rsp_ready;
  logic                             fma_issue;
  logic                             fma_sel;
  logic                             fma_stall;

  modport master (
    output req_valid, flush, rsp_ready,
    input  req_ready, rsp_valid, fma_issue, fma_sel, fma_stall
  );

  modport slave (
    input  req_valid, flush, rsp_ready,
    output req_ready, rsp_valid, fma_issue, fma_sel, fma_stall
  );

endinterface

// File: rtl/fma_arb_tagpipe.sv
// Ownership tag shadow of the FMA pipeline: shifts with the datapath, freezes on
// stall, and drops tags of a flushed owner. Entry LAT-1 is the FMA output stage.
module fma_tagpipe
  import fma_arb_pkg::*;
#(
  parameter int unsigned LAT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                issue,
  input  logic                sel,
  input  logic [FMA_NREQ-1:0] flush,
  output tag_t                head
);

  tag_t pipe [LAT];
  tag_t nxt  [LAT];

  always_comb begin
    nxt[0] = stall ? pipe[0] : tag_t'{valid: issue, owner: sel};
    for (int k = 1; k < LAT; k++) begin
      nxt[k] = stall ? pipe[k] : pipe[k-1];
    end
    // Flush is applied after the shift so a tag moving this edge is still caught.
    for (int k = 0; k < LAT; k++) begin
      if (flush[nxt[k].owner]) nxt[k].valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < LAT; k++) pipe[k] <= '0;
    end else begin
      for (int k = 0; k < LAT; k++) pipe[k] <= nxt[k];
    end
  end

  assign head = pipe[LAT-1];

endmodule

// File: rtl/fma_arb.sv
// Two-requester FMA issue arbiter with per-requester in-flight caps, flush and
// output backpressure. Define FMA_ARB_FAIR_EN for round-robin, else fixed priority.
module fma_arb
  import fma_arb_pkg::*;
#(
  parameter int unsigned LAT    = 4,
  parameter int unsigned MAXOUT = 3
) (
  input logic       clk,
  input logic       reset,
  fma_arb_if.slave  bus
);

  localparam int unsigned      CNT_W   = $clog2(MAXOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAXOUT);

  logic [CNT_W-1:0]    cnt [FMA_NREQ];
  logic [FMA_NREQ-1:0] elig;
  logic [FMA_NREQ-1:0] grant;
  logic [FMA_NREQ-1:0] retire;
  logic [FMA_NREQ-1:0] rsp_valid;
  logic                stall;
  logic                issue;
  tag_t                head;

  // Result presentation and backpressure from the head tag.
  always_comb begin
    rsp_valid = '0;
    stall     = 1'b0;
    if (!reset && head.valid && !bus.flush[head.owner]) begin
      rsp_valid[head.owner] = 1'b1;
      stall                 = !bus.rsp_ready[head.owner];
    end
    retire = rsp_valid & bus.rsp_ready;
  end

`ifdef FMA_ARB_FAIR_EN
  logic prio;

  // Favoured requester on contention: the one not granted most recently.
  always_ff @(posedge clk) begin
    if (reset)       prio <= FMA_REQ_FPU;
    else if (|grant) prio <= grant[FMA_REQ_FPU];
  end
`endif

  // A slot freed by a same-cycle retire may be reused immediately.
  always_comb begin
    elig  = '0;
    grant = '0;
    for (int i = 0; i < FMA_NREQ; i++) begin
      elig[i] = !reset && bus.req_valid[i] && !bus.flush[i] && !stall &&
                ((cnt[i] < CNT_MAX) || retire[i]);
    end
    case (elig)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
`ifdef FMA_ARB_FAIR_EN
      2'b11:   grant = prio ? 2'b10 : 2'b01;
`else
      2'b11:   grant = 2'b01;
`endif
      default: grant = 2'b00;
    endcase
  end

  assign issue         = |grant;
  assign bus.req_ready = grant;
  assign bus.fma_issue = issue;
  assign bus.fma_sel   = grant[FMA_REQ_DIV];
  assign bus.fma_stall = stall;
  assign bus.rsp_valid = rsp_valid;

  // In-flight counters per requester.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FMA_NREQ; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < FMA_NREQ; i++) begin
        if (bus.flush[i])                 cnt[i] <= '0;
        else if (grant[i] && !retire[i])  cnt[i] <= cnt[i] + 1'b1;
        else if (!grant[i] && retire[i])  cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  for (genvar g = 0; g < FMA_NREQ; g++) begin : g_cnt_chk
    a_cnt_max: assert property (@(posedge clk) disable iff (reset) cnt[g] <= CNT_MAX);
    a_cnt_min: assert property (@(posedge clk) disable iff (reset)
                                !(retire[g] && !grant[g] && (cnt[g] == '0)));
  end

  fma_tagpipe #(
    .LAT (LAT)
  ) u_tagpipe (
    .clk   (clk),
    .reset (reset),
    .stall (stall),
    .issue (issue),
    .sel   (grant[FMA_REQ_DIV]),
    .flush (bus.flush),
    .head  (head)
  );

endmodule
